// File: rtl/iterative_math_unit_if.sv
// Handshake/operand bundle between the control unit and the iterative math unit.
interface iterative_math_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] rem;
  logic [3:0]       flags;

  modport master (output start, mode, op_a, op_b,
                  input  busy, done, res, rem, flags);
  modport slave  (input  start, mode, op_a, op_b,
                  output busy, done, res, rem, flags);
endinterface

// File: rtl/iterative_math_unit.sv
// Multi-cycle coprocessor: factorial, power, restoring division and subtractive GCD
// behind a START/BUSY/DONE handshake; results and {Z,N,C,V} held until next accept.
module iterative_math_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  iterative_math_unit_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int DW = $clog2(WIDTH + 1);
  localparam int CW = (CNT_W > DW) ? CNT_W : DW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {M_FACT = 2'b00, M_POW = 2'b01, M_DIV = 2'b10, M_GCD = 2'b11} mode_t;

  state_t           r_state, w_state_nxt;
  mode_t            r_mode;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_res, r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [3:0]       r_flags;

  logic             w_accept, w_last, w_ovf_nxt;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt, w_res_fin, w_rem_fin;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_mul_b, w_prod;
  logic [WIDTH:0]   w_trial;

  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_FIN);

  // One multiplier shared by FACT (times counter) and POW (times latched OP_A).
  assign w_mul_b = (r_mode == M_FACT) ? PW'(r_cnt) : PW'(r_a);
  assign w_prod  = PW'(r_acc) * w_mul_b;
  assign w_trial = {r_acc, r_a[WIDTH-1]} - {1'b0, r_b};

  always_comb begin
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_last    = 1'b0;
    w_res_fin = r_acc;
    w_rem_fin = '0;
    case (r_mode)
      M_FACT, M_POW: begin
        if (r_cnt == '0) begin
          w_last = 1'b1;
        end else begin
          w_acc_nxt = w_prod[WIDTH-1:0];
          w_ovf_nxt = r_ovf | (|w_prod[PW-1:WIDTH]);
          w_cnt_nxt = r_cnt - CW'(1);
          w_last    = (r_cnt == CW'(1));
        end
        w_res_fin = w_acc_nxt;
      end
      M_DIV: begin
        if (r_b == '0) begin
          w_last    = 1'b1;
          w_res_fin = '1;
          w_rem_fin = r_a;
          w_ovf_nxt = 1'b1;
        end else begin
          // r_a shifts the dividend out and the quotient in; r_acc is the partial remainder.
          if (!w_trial[WIDTH]) begin
            w_acc_nxt = w_trial[WIDTH-1:0];
            w_a_nxt   = {r_a[WIDTH-2:0], 1'b1};
          end else begin
            w_acc_nxt = {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
            w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
          end
          w_cnt_nxt = r_cnt - CW'(1);
          w_last    = (r_cnt == CW'(1));
          w_res_fin = w_a_nxt;
          w_rem_fin = w_acc_nxt;
        end
      end
      M_GCD: begin
        if (r_a == '0 || r_b == '0 || r_a == r_b) begin
          w_last    = 1'b1;
          w_res_fin = (r_b == '0) ? r_a : r_b;
        end else if (r_a > r_b) begin
          w_a_nxt = r_a - r_b;
        end else begin
          w_b_nxt = r_b - r_a;
        end
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mode  <= M_FACT;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_res   <= '0;
      r_rem   <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mode  <= mode_t'(bus.mode);
        r_a     <= bus.op_a;
        r_b     <= bus.op_b;
        r_ovf   <= 1'b0;
        r_res   <= '0;
        r_rem   <= '0;
        r_flags <= '0;
        case (mode_t'(bus.mode))
          M_FACT: begin r_acc <= WIDTH'(1); r_cnt <= CW'(bus.op_a[CNT_W-1:0]); end
          M_POW:  begin r_acc <= WIDTH'(1); r_cnt <= CW'(bus.op_b[CNT_W-1:0]); end
          M_DIV:  begin r_acc <= '0;        r_cnt <= CW'(WIDTH);               end
          M_GCD:  begin r_acc <= '0;        r_cnt <= '0;                       end
        endcase
      end else if (r_state == S_RUN) begin
        r_a   <= w_a_nxt;
        r_b   <= w_b_nxt;
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
        if (w_last) begin
          r_res   <= w_res_fin;
          r_rem   <= w_rem_fin;
          r_flags <= {(w_res_fin == '0), w_res_fin[WIDTH-1],
                      (r_mode == M_DIV) && (w_rem_fin != '0), w_ovf_nxt};
        end
      end
    end
  end

  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_FIN);
  assign bus.res   = r_res;
  assign bus.rem   = r_rem;
  assign bus.flags = r_flags;
endmodule

// File: tb/tb_iterative_math_unit.sv
// Self-checking bench for iterative_math_unit: directed cases, randomized ops vs. an
// arithmetic reference model, reset abort, ignored START, back-to-back and RST priority.
module tb_iterative_math_unit;
  localparam int W     = 16;
  localparam int CNTW  = 9;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  iterative_math_unit_if #(.WIDTH(W)) u_if ();

  iterative_math_unit #(.WIDTH(W), .CNT_W(CNTW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] a, b, res, rem;
    logic [3:0]   fl;
    int           lat;
  } vec_t;

  // Reference: plain arithmetic; lat = RUN cycles + 1.
  function automatic void model(input logic [1:0] m, input logic [W-1:0] a, b,
                                output logic [W-1:0] res, rem, output logic [3:0] fl,
                                output int lat);
    longint lim = longint'(1) << W;
    longint r = 1, big = 1;
    bit     v = 0;
    int     n, k, x, y, t, s;
    res = '0;
    rem = '0;
    k   = 1;
    case (m)
      2'd0: begin
        n = int'(a[CNTW-1:0]);
        for (int i = 2; i <= n; i++) begin
          r   = (r * i) % lim;
          big = (big * i >= lim) ? lim : big * i;
        end
        v = (big >= lim);
        res = r[W-1:0];
        k = (n > 0) ? n : 1;
      end
      2'd1: begin
        n = int'(b[CNTW-1:0]);
        for (int i = 0; i < n; i++) begin
          r   = (r * longint'(a)) % lim;
          big = (big * longint'(a) >= lim) ? lim : big * longint'(a);
        end
        v = (big >= lim);
        res = r[W-1:0];
        k = (n > 0) ? n : 1;
      end
      2'd2: begin
        if (b == 0) begin res = '1; rem = a; v = 1; k = 1; end
        else begin res = a / b; rem = a % b; k = W; end
      end
      default: begin
        x = int'(a); y = int'(b);
        if (x == 0 || y == 0) begin
          res = (y == 0) ? a : b; k = 1;
        end else begin
          s = 0;
          while (y != 0) begin s += x / y; t = x % y; x = y; y = t; end
          res = W'(x); k = s;
        end
      end
    endcase
    fl  = {res == 0, res[W-1], (m == 2'd2) && (rem != 0), v};
    lat = k + 1;
  endfunction

  // Issue one op at the current negedge, then wait (bounded) for DONE.
  task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, b,
                       output int lat, output bit bok);
    u_if.start = 1'b1; u_if.mode = m; u_if.op_a = a; u_if.op_b = b;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.mode  = 2'($urandom);
    u_if.op_a  = W'($urandom);
    u_if.op_b  = W'($urandom);
    lat = 1; bok = 1;
    while (u_if.done !== 1'b1 && lat < LIMIT) begin
      if (u_if.busy !== 1'b1) bok = 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    u_if.start = 0; u_if.mode = 0; u_if.op_a = 0; u_if.op_b = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({u_if.busy, u_if.done, u_if.res, u_if.rem, u_if.flags} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h rem=%h flags=%b, want all 0",
               u_if.busy, u_if.done, u_if.res, u_if.rem, u_if.flags);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t tbl[12];
    int lat; bit bok;
    tbl = '{
      '{2'd0, 16'd5,   16'd0,  16'd120,    16'd0, 4'b0000, 6},
      '{2'd0, 16'd8,   16'd0,  16'h9D80,   16'd0, 4'b0100, 9},
      '{2'd0, 16'd9,   16'd0,  16'h8980,   16'd0, 4'b0101, 10},
      '{2'd0, 16'd0,   16'd0,  16'd1,      16'd0, 4'b0000, 2},
      '{2'd1, 16'd3,   16'd4,  16'd81,     16'd0, 4'b0000, 5},
      '{2'd1, 16'd2,   16'd0,  16'd1,      16'd0, 4'b0000, 2},
      '{2'd2, 16'd100, 16'd7,  16'd14,     16'd2, 4'b0010, 17},
      '{2'd2, 16'd5,   16'd0,  16'hFFFF,   16'd5, 4'b0111, 2},
      '{2'd2, 16'd0,   16'd5,  16'd0,      16'd0, 4'b1000, 17},
      '{2'd3, 16'd48,  16'd18, 16'd6,      16'd0, 4'b0000, 6},
      '{2'd3, 16'd0,   16'd9,  16'd9,      16'd0, 4'b0000, 2},
      '{2'd3, 16'd0,   16'd0,  16'd0,      16'd0, 4'b1000, 2}
    };
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].m, tbl[i].a, tbl[i].b, lat, bok);
      tests_run++;
      if ({u_if.res, u_if.rem, u_if.flags} !== {tbl[i].res, tbl[i].rem, tbl[i].fl}) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got res=%h rem=%h flags=%b, want res=%h rem=%h flags=%b",
                 i, u_if.res, u_if.rem, u_if.flags, tbl[i].res, tbl[i].rem, tbl[i].fl);
      end
      tests_run++;
      if (lat !== tbl[i].lat || !bok) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got lat=%0d busy_ok=%0d, want lat=%0d busy_ok=1",
                 i, lat, bok, tbl[i].lat);
      end
      @(negedge clk);
      tests_run++;
      if ({u_if.done, u_if.busy, u_if.res} !== {1'b0, 1'b0, tbl[i].res}) begin
        tests_failed++;
        $display("FAIL directed_after_done[%0d]: got done=%b busy=%b res=%h, want done=0 busy=0 res=%h",
                 i, u_if.done, u_if.busy, u_if.res, tbl[i].res);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] m; logic [W-1:0] a, b, er, em; logic [3:0] ef; int el, lat; bit bok;
    for (int i = 0; i < 60; i++) begin
      m = 2'($urandom_range(0, 3));
      case (m)
        2'd0: begin a = (W'($urandom) & 16'hFE00) | W'($urandom_range(0, 14)); b = W'($urandom); end
        2'd1: begin a = W'($urandom_range(0, 20)); b = (W'($urandom) & 16'hFE00) | W'($urandom_range(0, 12)); end
        2'd2: begin a = W'($urandom); b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 2000)); end
        default: begin
          a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
          b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
        end
      endcase
      model(m, a, b, er, em, ef, el);
      do_op(m, a, b, lat, bok);
      tests_run++;
      if ({u_if.res, u_if.rem, u_if.flags} !== {er, em, ef} || lat !== el || !bok) begin
        tests_failed++;
        $display("FAIL random[%0d] mode=%0d a=%h b=%h: got res=%h rem=%h flags=%b lat=%0d busy_ok=%0d, want res=%h rem=%h flags=%b lat=%0d",
                 i, m, a, b, u_if.res, u_if.rem, u_if.flags, lat, bok, er, em, ef, el);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0; int lat; bit bok;
    @(negedge clk);
    u_if.start = 1; u_if.mode = 2'd0; u_if.op_a = 16'd8; u_if.op_b = 0;
    @(negedge clk);
    u_if.start = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    tests_run++;
    if ({u_if.busy, u_if.done, u_if.res} !== '0) begin
      tests_failed++;
      $display("FAIL abort_reset: got busy=%b done=%b res=%h, want 0 0 0", u_if.busy, u_if.done, u_if.res);
    end
    for (int i = 0; i < 12; i++) begin
      if (u_if.done === 1'b1) dones++;
      @(negedge clk);
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d DONE cycles, want 0", dones);
    end
    do_op(2'd1, 16'd2, 16'd3, lat, bok);
    tests_run++;
    if (u_if.res !== 16'd8 || lat !== 4 || !bok) begin
      tests_failed++;
      $display("FAIL abort_then_pow: got res=%h lat=%0d busy_ok=%0d, want res=0008 lat=4", u_if.res, lat, bok);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat;
    u_if.start = 1; u_if.mode = 2'd1; u_if.op_a = 16'd3; u_if.op_b = 16'd4;
    @(negedge clk);
    lat = 1;
    tests_run++;
    if ({u_if.busy, u_if.res, u_if.rem, u_if.flags} !== {1'b1, 36'd0}) begin
      tests_failed++;
      $display("FAIL accept_clears: got busy=%b res=%h rem=%h flags=%b, want busy=1 res/rem/flags=0",
               u_if.busy, u_if.res, u_if.rem, u_if.flags);
    end
    u_if.start = 1; u_if.mode = 2'd2; u_if.op_a = 16'd9; u_if.op_b = 16'd0;
    @(negedge clk);
    u_if.start = 0;
    lat++;
    while (u_if.done !== 1'b1 && lat < LIMIT) begin @(negedge clk); lat++; end
    tests_run++;
    if (u_if.res !== 16'd81 || u_if.rem !== 16'd0 || lat !== 5) begin
      tests_failed++;
      $display("FAIL start_in_run: got res=%h rem=%h lat=%0d, want res=0051 rem=0000 lat=5", u_if.res, u_if.rem, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    do_op(2'd3, 16'd48, 16'd18, lat, bok);
    tests_run++;
    if (u_if.done !== 1'b1 || u_if.res !== 16'd6 || lat !== 6) begin
      tests_failed++;
      $display("FAIL b2b_first: got done=%b res=%h lat=%0d, want done=1 res=0006 lat=6", u_if.done, u_if.res, lat);
    end
    do_op(2'd2, 16'd100, 16'd7, lat, bok);
    tests_run++;
    if ({u_if.res, u_if.rem, u_if.flags} !== {16'd14, 16'd2, 4'b0010} || lat !== 17 || !bok) begin
      tests_failed++;
      $display("FAIL b2b_second: got res=%h rem=%h flags=%b lat=%0d busy_ok=%0d, want 000e 0002 0010 lat=17",
               u_if.res, u_if.rem, u_if.flags, lat, bok);
    end
    do_op(2'd0, 16'd5, 16'd0, lat, bok);
    tests_run++;
    if (u_if.res !== 16'd120 || u_if.rem !== 16'd0 || lat !== 6 || !bok) begin
      tests_failed++;
      $display("FAIL b2b_third: got res=%h rem=%h lat=%0d busy_ok=%0d, want res=0078 rem=0000 lat=6",
               u_if.res, u_if.rem, lat, bok);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_and_start();
    rst = 1;
    u_if.start = 1; u_if.mode = 2'd0; u_if.op_a = 16'd5; u_if.op_b = 0;
    @(negedge clk);
    rst = 0; u_if.start = 0;
    tests_run++;
    if ({u_if.busy, u_if.done, u_if.res} !== '0) begin
      tests_failed++;
      $display("FAIL rst_beats_start: got busy=%b done=%b res=%h, want 0 0 0", u_if.busy, u_if.done, u_if.res);
    end
    @(negedge clk);
    tests_run++;
    if ({u_if.busy, u_if.done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_start_idle: got busy=%b done=%b, want 0 0", u_if.busy, u_if.done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    test_rst_and_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/iterative_math_unit.md
# iterative_math_unit

Parametrised multi-cycle arithmetic coprocessor that generalises the core's fixed 9-bit factorial engine. It supports factorial, integer power, unsigned division and GCD at configurable data width, using a START/BUSY/DONE handshake. It sits beside the ALU: the control unit pulses START with operands, stalls while BUSY, and writes RES/REM and FLAGS back through the register write mux when DONE pulses.

## Interface
- WIDTH, 16, data width of operands and results (≥4)
- CNT_W, 9, width of the iteration counter; FACT and POW counts use OP_A[CNT_W-1:0] and OP_B[CNT_W-1:0] respectively
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  request; accepted only when BUSY=0
- MODE  in  2  00 FACT, 01 POW, 10 DIV, 11 GCD; sampled with START
- OP_A  in  WIDTH  operand A (unsigned), sampled with START
- OP_B  in  WIDTH  operand B (unsigned), sampled with START
- BUSY  out  1  high while iterating
- DONE  out  1  one-cycle pulse, results valid
- RES  out  WIDTH  result (quotient for DIV); held until the next accepted START
- REM  out  WIDTH  remainder for DIV, 0 for other modes
- FLAGS  out  4  {Z,N,C,V}; held with RES

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE→RUN on START.
  - RUN→FIN when the termination condition is met.
  - FIN→RUN on START (back-to-back), else FIN→IDLE.
- BUSY=1 only in RUN. DONE=1 only in FIN.
- START is ignored in RUN; MODE and operand changes are ignored in RUN.
- On accept: RES and REM clear to 0, FLAGS clear to 0, and operands are latched.
- FACT: acc=1, i=OP_A[CNT_W-1:0].
  - Each RUN cycle with i≥1: acc=acc*i, i=i-1.
  - i=0 on accept: one RUN cycle, no multiply.
  - Terminates when i reaches 0 or after the single zero cycle.
- POW: acc=1, k=OP_B[CNT_W-1:0].
  - Each RUN cycle: acc=acc*OP_A, k=k-1.
  - k=0 on accept: one cycle, result 1.
- Multiply width rule: full 2·WIDTH product; acc keeps the low WIDTH bits. V is set sticky if any high-half bit is nonzero.
- DIV: restoring, one quotient bit per cycle, MSB first, WIDTH RUN cycles. RES=OP_A/OP_B, REM=OP_A%OP_B.
  - OP_B=0: one RUN cycle, RES=all ones, REM=OP_A, V=1.
- GCD: a=OP_A, b=OP_B.
  - Each RUN cycle: if a=0 or b=0 or a=b, terminate with RES = a if b=0, else b.
  - Otherwise subtract the smaller value from the larger.
  - gcd(0,0)=0.
- FLAGS, computed on the final value and registered at RUN→FIN:
  - Z = (RES==0)
  - N = RES[WIDTH-1]
  - C = (DIV and REM≠0), else 0
  - V = overflow (FACT/POW) or divide-by-zero, else 0

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, RES=0, REM=0, FLAGS=0, internal counters 0.
- RST in any state (including mid-RUN) forces the reset values on the next edge. The aborted operation produces no DONE.
- START sampled at edge E0: BUSY=1 from E0 to E0+k, where k is the RUN cycle count. DONE=1 for the cycle after E0+k. Total START→DONE latency is k+1 cycles.
- RUN cycle count k:
  - FACT: max(n,1)
  - POW: max(OP_B,1)
  - DIV: WIDTH, or 1 when OP_B=0
  - GCD: number of subtractions + 1
- RES, REM and FLAGS change only at RUN→FIN (final values) and at START accept (cleared). They are stable whenever DONE=1.
- START coincident with FIN is accepted. DONE is still 1 that cycle, and BUSY=1 on the next cycle.
- RST and START in the same cycle: RST wins.

## Test plan
- WIDTH=16, FACT, OP_A=5 → DONE 6 cycles after START; RES=120, FLAGS=0000.
- FACT, OP_A=8 → RES=40320 (0x9D80), N=1, V=0. FACT, OP_A=9 → RES=35200 (0x8980), N=1, V=1.
- POW, OP_A=3, OP_B=4 → RES=81, DONE 5 cycles after START. POW with OP_B=0 → RES=1, DONE 2 cycles after START.
- DIV, 100/7 → RES=14, REM=2, C=1, DONE 17 cycles after START. DIV, 5/0 → RES=0xFFFF, REM=5, V=1, DONE 2 cycles after START.
- GCD, 48,18 → RES=6, DONE 6 cycles after START. GCD, 0,9 → RES=9, Z=0.
- FACT, OP_A=8, RST asserted 3 cycles after START → BUSY=0 and RES=0 on the next edge, no DONE. A following POW 2^3 accepted → RES=8. A START pulsed in RUN is ignored; a START in FIN is accepted back-to-back.
